// File: rtl/morse_pkg.sv
// Shared Morse timing constants, FSM state type and counter sizing.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } morse_state_e;

  localparam int TICK_DIV_DEF  = 25_000_000;
  localparam int GAP_UNITS_DEF = 7;

  // Counter must reach GAP_UNITS*TICK_DIV-1, which also covers the per-bit count.
  function automatic int cnt_width(input int tick_div, input int gap_units);
    int span;
    span = gap_units * tick_div;
    return (span < 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/morse_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, cyclically.
module morse_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o
);

  function automatic int wrap_idx(input int v);
    return (v >= NREQ) ? v - NREQ : v;
  endfunction

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!valid_o && req_i[j] && (j == wrap_idx(int'(ptr_i) + off))) begin
          gnt_o[j] = 1'b1;
          valid_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/morse_line_arbiter.sv
// Shares one Morse output line between NREQ bit-stream sources, round-robin,
// one bit per Morse unit, with a forced low word-gap after every message.
//
//   state | meaning
//   IDLE  | line low, waiting for a request
//   LOAD  | one cycle: latch granted source's bit and last flag onto the line
//   SEND  | hold the bit for the rest of the unit, pulse advance near unit end
//   GAP   | line low for GAP_UNITS units before the next grant
module morse_line_arbiter import morse_pkg::*; #(
  parameter int NREQ      = 2,
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int GAP_UNITS = GAP_UNITS_DEF
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [NREQ-1:0] iReq,
  input  logic [NREQ-1:0] iBit,
  input  logic [NREQ-1:0] iLast,
  input  logic            iAbort,
  output logic [NREQ-1:0] oGrant,
  output logic [NREQ-1:0] oAdvance,
  output logic            oLED,
  output logic            oBusy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = cnt_width(TICK_DIV, GAP_UNITS);

  localparam logic [CW-1:0] TICK_END  = CW'(TICK_DIV - 2);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP_UNITS * TICK_DIV - 1);
  localparam logic [PW-1:0] PTR_MAX   = PW'(NREQ - 1);

  morse_state_e    state_q;
  logic [NREQ-1:0] grant_q;
  logic            led_q;
  logic            last_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   rr_ptr_d;

  logic [NREQ-1:0] pick_gnt;
  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic            cur_bit;
  logic            cur_last;
  logic            cur_req;
  logic            xfer_kill;

  morse_rr_pick #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_pick (
    .req_i  (iReq),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (pick_gnt),
    .valid_o(pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (pick_gnt[j]) pick_idx = PW'(j);
    end
  end

  assign rr_ptr_d = (pick_idx == PTR_MAX) ? '0 : pick_idx + PW'(1);

  assign cur_bit  = |(iBit  & grant_q);
  assign cur_last = |(iLast & grant_q);
  assign cur_req  = |(iReq  & grant_q);

  // A granted source dropping its request is treated exactly like an abort.
  assign xfer_kill = iAbort || (((state_q == ST_LOAD) || (state_q == ST_SEND)) && !cur_req);

  // Advance is gated by the kill term so an abort on a tick-end edge never steps a source.
  assign oAdvance = ((state_q == ST_SEND) && (cnt_q == TICK_END) && !xfer_kill) ? grant_q : '0;
  assign oGrant   = grant_q;
  assign oLED     = led_q;
  assign oBusy    = (state_q != ST_IDLE);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      led_q    <= 1'b0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else if ((state_q != ST_IDLE) && xfer_kill) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      led_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid && !iAbort) begin
            grant_q  <= pick_gnt;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          led_q   <= cur_bit;
          last_q  <= cur_last;
          cnt_q   <= '0;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          // The final bit has no following LOAD cycle, so it stays one more cycle here.
          if (!last_q && (cnt_q == TICK_END)) begin
            cnt_q   <= '0;
            state_q <= ST_LOAD;
          end else if (last_q && (cnt_q == TICK_LAST)) begin
            cnt_q   <= '0;
            led_q   <= 1'b0;
            grant_q <= '0;
            state_q <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_END) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_line_arbiter.sv
// Directed bench for morse_line_arbiter with TICK_DIV=4, GAP_UNITS=2, NREQ=2.
module tb_morse_line_arbiter;

  logic       iCLK   = 1'b0;
  logic       iRST   = 1'b1;
  logic [1:0] iReq   = 2'b00;
  logic [1:0] iBit;
  logic [1:0] iLast;
  logic       iAbort = 1'b0;
  logic [1:0] oGrant;
  logic [1:0] oAdvance;
  logic       oLED;
  logic       oBusy;

  logic [15:0] pat [2];
  int len [2];
  int idx [2]     = '{0, 0};
  int adv_cnt [2] = '{0, 0};
  int n_chk = 0;
  int n_err = 0;

  morse_line_arbiter #(
    .NREQ     (2),
    .TICK_DIV (4),
    .GAP_UNITS(2)
  ) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iReq    (iReq),
    .iBit    (iBit),
    .iLast   (iLast),
    .iAbort  (iAbort),
    .oGrant  (oGrant),
    .oAdvance(oAdvance),
    .oLED    (oLED),
    .oBusy   (oBusy)
  );

  always #5 iCLK = ~iCLK;

  // Requester model: step read index on each sampled advance, restart when idle.
  always @(posedge iCLK) begin
    for (int k = 0; k < 2; k++) begin
      if (oAdvance[k]) adv_cnt[k] <= adv_cnt[k] + 1;
      if (iRST || !iReq[k]) idx[k] <= 0;
      else if (oAdvance[k]) idx[k] <= (idx[k] >= len[k] - 1) ? 0 : idx[k] + 1;
    end
  end

  always_comb begin
    iBit  = 2'b00;
    iLast = 2'b00;
    for (int k = 0; k < 2; k++) begin
      iBit[k]  = pat[k][idx[k]];
      iLast[k] = (idx[k] == len[k] - 1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
  endtask

  // Walks a full requester-0 message of n bits from the releasing negedge.
  task automatic check_msg(input string tag, input int n);
    logic [1:0] eg, ea;
    logic el, eb;
    for (int s = 1; s <= 4 * n + 10; s++) begin
      @(negedge iCLK);
      eg = (s <= 4 * n + 1) ? 2'b01 : 2'b00;
      el = (s >= 2 && s <= 4 * n + 1) ? pat[0][(s - 2) / 4] : 1'b0;
      ea = (s >= 4 && s <= 4 * n && ((s - 4) % 4 == 0)) ? 2'b01 : 2'b00;
      eb = (s <= 4 * n + 9);
      chk($sformatf("%s_grant_s%0d", tag, s), oGrant, eg);
      chk($sformatf("%s_led_s%0d", tag, s), oLED, el);
      chk($sformatf("%s_adv_s%0d", tag, s), oAdvance, ea);
      chk($sformatf("%s_busy_s%0d", tag, s), oBusy, eb);
      if (s == 4 * n + 2) iReq = 2'b00;
    end
  endtask

  task automatic run_msg(input string tag, input logic [1:0] exp, output int zeros);
    int t;
    zeros = 0;
    while (oGrant == 2'b00 && zeros < 200) begin
      zeros++;
      @(negedge iCLK);
    end
    chk({tag, "_grant"}, oGrant, exp);
    t = 0;
    while (oGrant != 2'b00 && t < 500) begin
      t++;
      @(negedge iCLK);
    end
    chk({tag, "_ends"}, (t < 500), 1);
  endtask

  initial begin
    int z, b0, b1;
    pat[0] = 16'b0; pat[1] = 16'b0;
    len[0] = 1;     len[1] = 1;

    // reset state
    @(negedge iCLK);
    @(negedge iCLK);
    chk("rst_grant", oGrant, 2'b00);
    chk("rst_led", oLED, 1'b0);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_adv", oAdvance, 2'b00);
    iRST = 1'b0;
    @(negedge iCLK);
    chk("idle_busy", oBusy, 1'b0);

    // single message 1,0,1,1,1
    pat[0] = 16'b11101; len[0] = 5; iReq = 2'b00;
    do_reset();
    b0 = adv_cnt[0];
    iReq = 2'b01;
    check_msg("single", 5);
    chk("single_adv_total", adv_cnt[0] - b0, 5);

    // simultaneous requests, round-robin 0,1,0,1 with gaps
    pat[0] = 16'b101; len[0] = 3;
    pat[1] = 16'b10;  len[1] = 2;
    iReq = 2'b11;
    do_reset();
    b0 = adv_cnt[0]; b1 = adv_cnt[1];
    run_msg("rr_m1", 2'b01, z); chk("rr_m1_wait", z, 1);
    run_msg("rr_m2", 2'b10, z); chk("rr_m2_gap", z, 9);
    run_msg("rr_m3", 2'b01, z); chk("rr_m3_gap", z, 9);
    run_msg("rr_m4", 2'b10, z); chk("rr_m4_gap", z, 9);
    chk("rr_adv0_total", adv_cnt[0] - b0, 6);
    chk("rr_adv1_total", adv_cnt[1] - b1, 4);

    // abort on a tick-end edge
    pat[0] = 16'b00011; len[0] = 5; iReq = 2'b11;
    do_reset();
    b0 = adv_cnt[0];
    repeat (8) @(negedge iCLK);
    chk("abort_adv_pre", oAdvance, 2'b01);
    chk("abort_led_pre", oLED, 1'b1);
    iAbort = 1'b1;
    #1;
    chk("abort_adv_gated", oAdvance, 2'b00);
    @(negedge iCLK);
    iAbort = 1'b0;
    chk("abort_led", oLED, 1'b0);
    chk("abort_grant", oGrant, 2'b00);
    chk("abort_busy", oBusy, 1'b0);
    chk("abort_adv_total", adv_cnt[0] - b0, 1);
    @(negedge iCLK);
    chk("abort_next_grant", oGrant, 2'b10);
    iReq = 2'b00;

    // withdrawal on the tick-end cycle
    pat[0] = 16'b11101; len[0] = 5; iReq = 2'b01;
    do_reset();
    b0 = adv_cnt[0];
    repeat (4) @(negedge iCLK);
    chk("wd_adv_pre", oAdvance, 2'b01);
    chk("wd_led_pre", oLED, 1'b1);
    iReq = 2'b00;
    #1;
    chk("wd_adv_gated", oAdvance, 2'b00);
    @(negedge iCLK);
    chk("wd_grant", oGrant, 2'b00);
    chk("wd_led", oLED, 1'b0);
    chk("wd_busy", oBusy, 1'b0);
    repeat (6) @(negedge iCLK);
    chk("wd_adv_total", adv_cnt[0] - b0, 0);
    chk("wd_grant_late", oGrant, 2'b00);

    // async reset mid-SEND
    pat[0] = 16'b11101; len[0] = 5; iReq = 2'b01;
    do_reset();
    repeat (2) @(negedge iCLK);
    chk("ar_led_pre", oLED, 1'b1);
    iReq = 2'b11;
    #2 iRST = 1'b1;
    #1;
    chk("ar_grant", oGrant, 2'b00);
    chk("ar_led", oLED, 1'b0);
    chk("ar_busy", oBusy, 1'b0);
    chk("ar_adv", oAdvance, 2'b00);
    @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
    chk("ar_first_grant", oGrant, 2'b01);
    iReq = 2'b00;

    // one-bit message
    pat[0] = 16'b1; len[0] = 1; iReq = 2'b00;
    do_reset();
    b0 = adv_cnt[0];
    iReq = 2'b01;
    check_msg("onebit", 1);
    chk("onebit_adv_total", adv_cnt[0] - b0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
